// File: rtl/eq_pkg.sv
// Shared constants and types for the equalizer band mixer datapath.
package eq_pkg;

    localparam int NBANDS    = 8;
    localparam int IN_W      = 32;
    localparam int GAIN_W    = 16;
    localparam int OUT_W     = 16;
    localparam int OUT_SHIFT = 12;

    localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h1000;

    // Sum of NBANDS full-scale products cannot exceed this width.
    localparam int ACC_W = IN_W + GAIN_W + $clog2(NBANDS);

    localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OUT_W - 1));

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        ROUND,
        OUT
    } state_t;

endpackage

// File: rtl/eq_round_sat.sv
// Round-half-up, arithmetic shift and clip of a wide signed accumulator.
module eq_round_sat
    import eq_pkg::*;
#(
    parameter int WIDTH     = ACC_W,
    parameter int OUT_WIDTH = OUT_W,
    parameter int SHIFT     = OUT_SHIFT,
    parameter int LIM_HI    = SAT_MAX,
    parameter int LIM_LO    = SAT_MIN
) (
    input  logic signed [WIDTH-1:0]     acc,
    output logic signed [OUT_WIDTH-1:0] y,
    output logic                        sat
);

    localparam logic signed [WIDTH-1:0] HALF = WIDTH'(1) << (SHIFT - 1);
    localparam logic signed [WIDTH-1:0] HI   = WIDTH'(LIM_HI);
    localparam logic signed [WIDTH-1:0] LO   = WIDTH'(LIM_LO);

    logic signed [WIDTH-1:0] r;

    always_comb begin
        r = (acc + HALF) >>> SHIFT;
        if (r > HI) begin
            y   = OUT_WIDTH'(LIM_HI);
            sat = 1'b1;
        end else if (r < LO) begin
            y   = OUT_WIDTH'(LIM_LO);
            sat = 1'b1;
        end else begin
            y   = r[OUT_WIDTH-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/eq_band_mixer.sv
// Mixes eight band-filter outputs through per-band gains with one shared MAC,
// then rounds and saturates to the output sample width.
module eq_band_mixer
    import eq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NBANDS*IN_W-1:0] band_in,
    input  logic                   gain_we,
    input  logic [2:0]             gain_addr,
    input  logic [GAIN_W-1:0]      gain_wdata,
    output logic [OUT_W-1:0]       y_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sat_flag
);

    localparam int IDX_W  = $clog2(NBANDS);
    localparam int K_W    = $clog2(NBANDS + 1);
    localparam int PROD_W = IN_W + GAIN_W;

    state_t                    state;
    logic [K_W-1:0]            k;
    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   acc;
    logic signed [PROD_W-1:0]  prod;
    logic signed [IN_W-1:0]    sample    [NBANDS];
    logic signed [GAIN_W-1:0]  shadow    [NBANDS];
    logic signed [GAIN_W-1:0]  shadow_nx [NBANDS];
    logic signed [GAIN_W-1:0]  active    [NBANDS];
    logic signed [OUT_W-1:0]   rnd_y;
    logic                      rnd_sat;

    assign idx      = k[IDX_W-1:0];
    assign in_ready = ena && (state == IDLE);

    // Same-edge write lands in both the shadow bank and the accept-time copy.
    always_comb begin
        for (int unsigned i = 0; i < NBANDS; i++) shadow_nx[i] = shadow[i];
        if (gain_we) shadow_nx[gain_addr] = gain_wdata;
    end

    eq_round_sat u_round_sat (
        .acc (acc),
        .y   (rnd_y),
        .sat (rnd_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            acc       <= '0;
            prod      <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            for (int unsigned i = 0; i < NBANDS; i++) begin
                shadow[i] <= GAIN_UNITY;
                active[i] <= GAIN_UNITY;
            end
        end else begin
            for (int unsigned i = 0; i < NBANDS; i++) shadow[i] <= shadow_nx[i];
            if (!ena) begin
                state     <= IDLE;
                k         <= '0;
                acc       <= '0;
                prod      <= '0;
                y_out     <= '0;
                out_valid <= 1'b0;
                sat_flag  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            for (int unsigned i = 0; i < NBANDS; i++) begin
                                sample[i] <= band_in[i*IN_W +: IN_W];
                                active[i] <= shadow_nx[i];
                            end
                            acc   <= '0;
                            prod  <= '0;
                            k     <= '0;
                            state <= ACC;
                        end
                    end
                    // Product is registered, so the last band is summed one
                    // pass after it is multiplied (k runs 0..NBANDS).
                    ACC: begin
                        prod <= sample[idx] * active[idx];
                        acc  <= acc + ACC_W'(prod);
                        k    <= k + 1'b1;
                        if (k == K_W'(NBANDS)) state <= ROUND;
                    end
                    ROUND: begin
                        y_out     <= rnd_y;
                        sat_flag  <= rnd_sat;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                    OUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Self-checking bench for eq_band_mixer: vector table plus handshake, gain and abort sequences.
module tb_eq_band_mixer;
    import eq_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst, ena, in_valid, in_ready, gain_we;
    logic                   out_valid, out_ready, sat_flag;
    logic [NBANDS*IN_W-1:0] band_in;
    logic [2:0]             gain_addr;
    logic [GAIN_W-1:0]      gain_wdata;
    logic [OUT_W-1:0]       y_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [NBANDS*IN_W-1:0] bands;
        logic [GAIN_W-1:0]      g0;
        logic [OUT_W-1:0]       y;
        logic                   sat;
    } vec_t;

    typedef struct {
        logic [OUT_W-1:0] y;
        logic             sat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    eq_band_mixer dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .band_in    (band_in),
        .gain_we    (gain_we),
        .gain_addr  (gain_addr),
        .gain_wdata (gain_wdata),
        .y_out      (y_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NBANDS*IN_W-1:0] one_band(input int k, input logic [IN_W-1:0] v);
        logic [NBANDS*IN_W-1:0] r;
        r = '0;
        r[k*IN_W +: IN_W] = v;
        return r;
    endfunction

    function automatic logic [NBANDS*IN_W-1:0] all_bands(input logic [IN_W-1:0] v);
        logic [NBANDS*IN_W-1:0] r;
        for (int i = 0; i < NBANDS; i++) r[i*IN_W +: IN_W] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [OUT_W-1:0] y, input logic sat);
        exp_t e;
        e.y   = y;
        e.sat = sat;
        sb.push_back(e);
    endtask

    task automatic write_gain(input logic [2:0] a, input logic [GAIN_W-1:0] d);
        gain_we = 1'b1; gain_addr = a; gain_wdata = d;
        tick();
        gain_we = 1'b0;
    endtask

    task automatic send(input logic [NBANDS*IN_W-1:0] b, output int acc_cyc);
        logic rdy;
        logic done;
        done = 1'b0;
        acc_cyc = -1;
        band_in = b;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin
                done = 1'b1;
                acc_cyc = cyc;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (in_ready) done = 1'b1;
            else tick();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_idle_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic wait_valid(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (out_valid) done = 1'b1;
            else tick();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_valid_timeout actual=0 required=1", name);
        end
    endtask

    // Scoreboard: every completed output handshake pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output actual=%0h required=none", y_out);
            end else begin
                e = sb.pop_front();
                check("sb_y", {48'd0, y_out}, {48'd0, e.y});
                check("sb_sat", {63'd0, sat_flag}, {63'd0, e.sat});
            end
        end
    end

    initial begin
        int acc_cyc, lat, low;

        vecs.push_back('{all_bands(32'd1000),       16'h1000, 16'd8000,   1'b0});
        vecs.push_back('{one_band(3, 32'h7FFFFFFF), 16'h1000, 16'h7FFF,   1'b1});
        vecs.push_back('{one_band(3, 32'h80000000), 16'h1000, 16'h8000,   1'b1});
        vecs.push_back('{one_band(0, 32'd32767),    16'h1000, 16'd32767,  1'b0});
        vecs.push_back('{one_band(0, 32'd32768),    16'h1000, 16'd32767,  1'b1});
        vecs.push_back('{one_band(0, -32'sd32768),  16'h1000, 16'h8000,   1'b0});
        vecs.push_back('{one_band(0, -32'sd32769),  16'h1000, 16'h8000,   1'b1});
        vecs.push_back('{one_band(0, 32'd3),        16'h0800, 16'd2,      1'b0});
        vecs.push_back('{one_band(0, -32'sd3),      16'h0800, 16'hFFFF,   1'b0});
        vecs.push_back('{one_band(0, -32'sd5000),   16'h0800, -16'sd2500, 1'b0});
        vecs.push_back('{one_band(0, 32'd1),        16'h0800, 16'd1,      1'b0});
        vecs.push_back('{one_band(0, -32'sd1),      16'h0800, 16'd0,      1'b0});

        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; gain_we = 1'b0;
        gain_addr = '0; gain_wdata = '0; out_ready = 1'b1; band_in = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_y", {48'd0, y_out}, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sat", {63'd0, sat_flag}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Latency and busy window with reset (unity) gains.
        push(16'd8000, 1'b0);
        send(all_bands(32'd1000), acc_cyc);
        lat = -1; low = 0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) break;
            low++;
            if (out_valid && lat < 0) lat = cyc - acc_cyc;
            tick();
        end
        check("latency", 64'(lat), 64'd10);
        check("busy_cycles", 64'(low), 64'd11);

        // Table-driven vectors.
        foreach (vecs[n]) begin
            write_gain(3'd0, vecs[n].g0);
            push(vecs[n].y, vecs[n].sat);
            send(vecs[n].bands, acc_cyc);
            drain("vec");
        end
        write_gain(3'd0, GAIN_UNITY);

        // Backpressure with in_valid pulsed while the result is held.
        out_ready = 1'b0;
        push(16'd1600, 1'b0);
        send(all_bands(32'd200), acc_cyc);
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            band_in = all_bands(32'd7);
            check("bp_y", {48'd0, y_out}, 64'd1600);
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", {63'd0, out_valid}, 64'd0);
        check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        push(16'd80, 1'b0);
        send(all_bands(32'd10), acc_cyc);
        drain("bp_next");

        // Gain write mid-sample only affects the following sample.
        push(16'd800, 1'b0);
        send(all_bands(32'd100), acc_cyc);
        tick(); tick(); tick();
        write_gain(3'd2, 16'h2000);
        drain("gw_cur");
        push(16'd900, 1'b0);
        send(all_bands(32'd100), acc_cyc);
        drain("gw_next");
        write_gain(3'd2, GAIN_UNITY);

        // Abort by dropping ena during accumulation.
        send(all_bands(32'd50), acc_cyc);
        tick(); tick(); tick();
        ena = 1'b0;
        tick();
        check("abort_y", {48'd0, y_out}, 64'd0);
        check("abort_sat", {63'd0, sat_flag}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1;
        band_in = all_bands(32'd50);
        for (int i = 0; i < 12; i++) begin
            check("abort_valid", {63'd0, out_valid}, 64'd0);
            tick();
        end
        in_valid = 1'b0;
        ena = 1'b1;
        tick();
        check("reenable_ready", {63'd0, in_ready}, 64'd1);
        push(16'd80, 1'b0);
        send(all_bands(32'd10), acc_cyc);
        drain("reenable");

        // Reset while holding a result restores unity gains.
        write_gain(3'd0, 16'h2000);
        out_ready = 1'b0;
        send(all_bands(32'd10), acc_cyc);
        wait_valid("rst_out");
        check("rst_out_pre_y", {48'd0, y_out}, 64'd90);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_y", {48'd0, y_out}, 64'd0);
        out_ready = 1'b1;
        push(16'd80, 1'b0);
        send(all_bands(32'd10), acc_cyc);
        drain("post_rst");

        tick(); tick();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
